pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning the number of cycles flush_o is held per exception (legal 1..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port stallreq_id, input, 1, load-use stall request from decode.
REQ-005 SHALL have port stallreq_ex, input, 1, multi-cycle execute-op stall request.
REQ-006 SHALL have port stallreq_mem, input, 1, memory-bus wait stall request.
REQ-007 SHALL have port branch_flag_i, input, 1, taken branch or jump resolved in decode.
REQ-008 SHALL have port branch_target_addr_i, input, 32, branch target from decode.
REQ-009 SHALL have port excp_valid_i, input, 1, exception committed in the memory stage.
REQ-010 SHALL have port excp_handler_i, input, 32, exception handler address.
REQ-011 SHALL have port stall_o, output, 6, stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-012 SHALL have port flush_o, output, 1, clear all pipeline registers.
REQ-013 SHALL have port redirect_o, output, 1, pc loads new_pc_o this cycle.
REQ-014 SHALL have port new_pc_o, output, 32, redirect address.
REQ-015 SHALL have port delay_slot_o, output, 1, the instruction now in decode is a delay slot.
REQ-016 SHALL have port state_o, output, 2, FSM state: 0 RUN, 1 STALL, 2 FLUSH.
REQ-017 SHALL have port stall_cycles_o, output, 32, stall-cycle counter.
REQ-018 SHALL have port flush_count_o, output, 16, exception-flush counter.

Function
REQ-019 SHALL implement an FSM with states RUN, STALL and FLUSH.
REQ-020 SHALL give excp_valid_i, in any state except FLUSH, the highest priority: next state FLUSH, with a flush counter loaded to FLUSH_CYCLES-1.
REQ-021 SHALL, in FLUSH, drive flush_o=1 and stall_o=0, and drive redirect_o=1 with new_pc_o equal to the handler captured on entry, in the first FLUSH cycle only.
REQ-022 SHALL leave FLUSH when the flush counter reaches 0, going to STALL if any stall request is active and to RUN otherwise.
REQ-023 SHALL ignore excp_valid_i and all stall requests while in FLUSH.
REQ-024 SHALL, outside FLUSH, decode stall_o combinationally in the same cycle as the requests: stallreq_mem gives 011111; otherwise stallreq_ex gives 001111; otherwise stallreq_id gives 000111; no request gives 000000.
REQ-025 SHALL, when excp_valid_i and a stall request are both active in the same cycle, have the stall decode and the FSM transition both apply: stall_o follows the request that cycle and the FSM enters FLUSH on the next edge.
REQ-026 SHALL move RUN to STALL when any request is active, and STALL to RUN when none is active.
REQ-027 SHALL, when branch_flag_i=1, stall_o[2]=0 and not in FLUSH, drive redirect_o=1 and new_pc_o=branch_target_addr_i combinationally.
REQ-028 SHALL give an exception redirect priority over a branch redirect.
REQ-029 SHALL set delay_slot_o on the edge after an accepted branch (the cycle of REQ-027).
REQ-030 SHALL hold delay_slot_o while stall_o[2]=1, and clear it on the next edge where decode advances.
REQ-031 SHALL clear delay_slot_o on entry to FLUSH.
REQ-032 SHALL drive new_pc_o=0 whenever redirect_o=0.

Reset
REQ-033 SHALL, while rst=1 and independent of clk, force state RUN, flush counter 0, delay_slot_o 0, captured handler 0 and both perf counters 0.
REQ-034 SHALL, while rst=1, force outputs stall_o=0, flush_o=0, redirect_o=0 and new_pc_o=0.
REQ-035 SHALL abort a FLUSH in progress when rst is asserted, resuming in RUN after release.

Configuration
REQ-036 SHALL compile the performance counters in when PIPE_CTRL_PERF_EN is defined.
REQ-037 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cycles_o each cycle stall_o is non-zero, saturating at FFFFFFFF.
REQ-038 SHALL, with PIPE_CTRL_PERF_EN defined, increment flush_count_o on each FLUSH entry, wrapping at 16 bits.
REQ-039 SHALL, without PIPE_CTRL_PERF_EN, keep both counter ports and tie them to 0, with no counter flops.

Verification
REQ-040 SHALL cover: stallreq_ex=1 for 3 cycles -> stall_o=001111 in those 3 cycles, state_o=1 from the second, RUN afterwards, stall_cycles_o=3 (macro on).
REQ-041 SHALL cover: stallreq_id and stallreq_mem together -> stall_o=011111.
REQ-042 SHALL cover: branch_flag_i=1 with target 0x80001000, no stall -> redirect_o=1 and new_pc_o=0x80001000 same cycle, delay_slot_o=1 next cycle.
REQ-043 SHALL cover: branch accepted, then stallreq_id for 2 cycles -> delay_slot_o held 1 for 3 cycles, then 0.
REQ-044 SHALL cover: FLUSH_CYCLES=2 and excp_valid_i with handler 0xBFC00380 during stallreq_mem -> next two cycles flush_o=1 and stall_o=0, redirect_o only in the first with new_pc_o=0xBFC00380, flush_count_o=1.
REQ-045 SHALL cover: rst pulsed mid-FLUSH -> all outputs 0 immediately, state_o=0, counters cleared.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall decode, branch/exception redirect and flush sequencing.
// Optional performance counters compiled in with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic        excp_valid_i,
  input  logic [31:0] excp_handler_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o,
  output logic        delay_slot_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [31:0] handler_q;
  logic        ds_q, ds_d;
  logic        any_req, in_flush, flush_enter, br_take;
  logic [5:0]  stall_dec;

  assign any_req     = stallreq_id | stallreq_ex | stallreq_mem;
  assign in_flush    = (state_q == FLUSH);
  assign flush_enter = !in_flush && excp_valid_i;
  assign br_take     = !in_flush && branch_flag_i && !stall_dec[2];

  always_comb begin
    stall_dec = 6'b000000;
    if (stallreq_mem)     stall_dec = 6'b011111;
    else if (stallreq_ex) stall_dec = 6'b001111;
    else if (stallreq_id) stall_dec = 6'b000111;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      FLUSH: begin
        if (fcnt_q == 2'd0) state_d = any_req ? STALL : RUN;
        else                fcnt_d  = fcnt_q - 2'd1;
      end
      default: begin
        if (excp_valid_i) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_INIT;
        end else begin
          state_d = any_req ? STALL : RUN;
        end
      end
    endcase
  end

  // The counter still equals its load value only in the first FLUSH cycle.
  always_comb begin
    stall_o    = 6'b000000;
    flush_o    = 1'b0;
    redirect_o = 1'b0;
    new_pc_o   = 32'h0;
    if (!rst) begin
      if (in_flush) begin
        flush_o = 1'b1;
        if (fcnt_q == FCNT_INIT) begin
          redirect_o = 1'b1;
          new_pc_o   = handler_q;
        end
      end else begin
        stall_o = stall_dec;
        if (br_take) begin
          redirect_o = 1'b1;
          new_pc_o   = branch_target_addr_i;
        end
      end
    end
  end

  always_comb begin
    ds_d = ds_q;
    if (flush_enter)      ds_d = 1'b0;
    else if (br_take)     ds_d = 1'b1;
    else if (!stall_o[2]) ds_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      fcnt_q    <= 2'd0;
      ds_q      <= 1'b0;
      handler_q <= 32'h0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ds_q    <= ds_d;
      if (flush_enter) handler_q <= excp_handler_i;
    end
  end

  assign delay_slot_o = ds_q;
  assign state_o      = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [15:0] flush_num_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= 32'h0;
      flush_num_q <= 16'h0;
    end else begin
      if ((|stall_o) && (stall_cyc_q != 32'hFFFF_FFFF)) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (flush_enter) flush_num_q <= flush_num_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_cyc_q;
  assign flush_count_o  = flush_num_q;
`else
  assign stall_cycles_o = 32'h0;
  assign flush_count_o  = 16'h0;
`endif

endmodule
